rom_req_ctrl: RTL and testbench

ROM_REQ_CTRL -- requirements
Module: rom_req_ctrl

---
 rtl/rom_req_ctrl.sv | 159 +++++++++++++++
 tb/tb_rom_req_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_req_ctrl.sv
// rtl/rom_req_ctrl.sv - ROM read front end: line buffer plus SDRAM demand-fetch FSM
// Optional next-word prefetch buffer is compiled in when ROM_PREFETCH_EN is defined.
module rom_req_ctrl #(
  parameter int ADDR_W = 24
) (
  input  logic              MCLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ROM_ADDR,
  input  logic              ROM_CE_N,
  input  logic              ROM_OE_N,
  input  logic              ROM_WORD,
  output logic [15:0]       ROM_Q,
  output logic [ADDR_W-2:0] MEM_ADDR,
  output logic              MEM_REQ,
  input  logic              MEM_ACK,
  input  logic [15:0]       MEM_Q,
  output logic              BUSY
);

  localparam int WA_W = ADDR_W - 1;

`ifdef ROM_PREFETCH_EN
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_PREF} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
`endif

  state_t            state;
  state_t            state_nx;
  logic [WA_W-1:0]   word_addr;
  logic              rd_en;
  logic              line_hit;
  logic              pf_hit;
  logic              demand;
  logic              fetching;
  logic              addr_moved;
  logic              fill_ok;
  logic              stale;
  logic              line_valid;
  logic [WA_W-1:0]   line_tag;
  logic [15:0]       line_data;
  logic [7:0]        sel_byte;

  assign word_addr  = ROM_ADDR[ADDR_W-1:1];
  assign rd_en      = !ROM_CE_N && !ROM_OE_N;
  assign line_hit   = rd_en && line_valid && (line_tag == word_addr);
  assign fetching   = (state == ST_REQ) || (state == ST_WAIT);
  // A demand fill is kept only if the mapper is still reading the word we asked for.
  assign addr_moved = rd_en && (word_addr != MEM_ADDR);
  assign fill_ok    = fetching && MEM_ACK && !stale && !addr_moved;
  assign sel_byte   = ROM_ADDR[0] ? line_data[15:8] : line_data[7:0];

`ifdef ROM_PREFETCH_EN
  logic              pf_valid;
  logic [WA_W-1:0]   pf_tag;
  logic [15:0]       pf_data;

  assign pf_hit = rd_en && !line_hit && pf_valid && (pf_tag == word_addr) && (state == ST_IDLE);
`else
  assign pf_hit = 1'b0;
`endif

  assign demand = rd_en && !line_hit && !pf_hit;

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (demand) begin
          state_nx = ST_REQ;
        end
      end
      ST_REQ, ST_WAIT: begin
        if (MEM_ACK) begin
`ifdef ROM_PREFETCH_EN
          state_nx = fill_ok ? ST_PREF : ST_IDLE;
`else
          state_nx = ST_IDLE;
`endif
        end else begin
          state_nx = ST_WAIT;
        end
      end
`ifdef ROM_PREFETCH_EN
      ST_PREF: begin
        if (MEM_ACK) begin
          state_nx = ST_IDLE;
        end
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    MEM_REQ = (state != ST_IDLE);
    BUSY    = !RESET && ((state != ST_IDLE) || demand);
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      MEM_ADDR   <= '0;
      stale      <= 1'b0;
      line_valid <= 1'b0;
      line_tag   <= '0;
      line_data  <= '0;
      ROM_Q      <= '0;
`ifdef ROM_PREFETCH_EN
      pf_valid   <= 1'b0;
      pf_tag     <= '0;
      pf_data    <= '0;
`endif
    end else begin
      if ((state == ST_IDLE) && demand) begin
        MEM_ADDR <= word_addr;
        stale    <= 1'b0;
      end else if (fetching && addr_moved) begin
        stale    <= 1'b1;
      end

      if (fill_ok) begin
        line_valid <= 1'b1;
        line_tag   <= MEM_ADDR;
        line_data  <= MEM_Q;
      end

`ifdef ROM_PREFETCH_EN
      // Next word wraps naturally at the word-address width.
      if (fill_ok) begin
        MEM_ADDR <= MEM_ADDR + WA_W'(1);
      end
      if ((state == ST_PREF) && MEM_ACK) begin
        pf_valid <= 1'b1;
        pf_tag   <= MEM_ADDR;
        pf_data  <= MEM_Q;
      end
      if (pf_hit) begin
        line_valid <= 1'b1;
        line_tag   <= pf_tag;
        line_data  <= pf_data;
        pf_valid   <= 1'b0;
      end
`endif

      if (line_hit) begin
        ROM_Q <= ROM_WORD ? line_data : {sel_byte, sel_byte};
      end
    end
  end

endmodule

// File: tb/tb_rom_req_ctrl.sv
// tb/tb_rom_req_ctrl.sv - directed table-driven bench for rom_req_ctrl
module tb_rom_req_ctrl;

  logic        MCLK = 1'b0;
  logic        RESET;
  logic [23:0] ROM_ADDR;
  logic        ROM_CE_N;
  logic        ROM_OE_N;
  logic        ROM_WORD;
  logic [15:0] ROM_Q;
  logic [22:0] MEM_ADDR;
  logic        MEM_REQ;
  logic        MEM_ACK;
  logic [15:0] MEM_Q;
  logic        BUSY;

  int checks   = 0;
  int failures = 0;

  rom_req_ctrl #(.ADDR_W(24)) dut (
    .MCLK     (MCLK),
    .RESET    (RESET),
    .ROM_ADDR (ROM_ADDR),
    .ROM_CE_N (ROM_CE_N),
    .ROM_OE_N (ROM_OE_N),
    .ROM_WORD (ROM_WORD),
    .ROM_Q    (ROM_Q),
    .MEM_ADDR (MEM_ADDR),
    .MEM_REQ  (MEM_REQ),
    .MEM_ACK  (MEM_ACK),
    .MEM_Q    (MEM_Q),
    .BUSY     (BUSY)
  );

  always #5 MCLK = ~MCLK;

  function automatic logic [15:0] mem_model(input logic [22:0] a);
    return (a == 23'h000080) ? 16'hBEEF : (a[15:0] ^ 16'h5AC3);
  endfunction

  // SDRAM responder: acks after lat cycles of MEM_REQ, or once on a manual request.
  int          lat      = 3;
  bit          auto_ack = 1'b1;
  int          man_seq  = 0;
  int          man_done = 0;
  logic [15:0] man_q    = 16'h0000;
  int          cnt      = 0;
  logic [22:0] req_log[$];

  initial begin
    MEM_ACK = 1'b0;
    MEM_Q   = 16'h0000;
  end

  always @(negedge MCLK) begin
    MEM_ACK = 1'b0;
    if (man_seq != man_done) begin
      MEM_ACK  = 1'b1;
      MEM_Q    = man_q;
      man_done = man_seq;
    end else if (auto_ack && MEM_REQ && !RESET) begin
      cnt = cnt + 1;
      if (cnt >= lat) begin
        MEM_ACK = 1'b1;
        MEM_Q   = mem_model(MEM_ADDR);
        req_log.push_back(MEM_ADDR);
        cnt     = 0;
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    @(negedge MCLK);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((MEM_REQ || BUSY) && n < 80) begin
      tick();
      n++;
    end
    check(name, {31'd0, MEM_REQ || BUSY}, 32'd0);
  endtask

  task automatic apply(input logic [23:0] a, input logic ce_n, input logic oe_n, input logic w);
    ROM_ADDR = a;
    ROM_CE_N = ce_n;
    ROM_OE_N = oe_n;
    ROM_WORD = w;
  endtask

  task automatic reset_pulse();
    apply(24'h0, 1'b1, 1'b1, 1'b1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [23:0] addr;
    logic        ce_n;
    logic        oe_n;
    logic        word;
    logic [15:0] exp_q;
  } hit_vec_t;

  typedef struct {
    logic [23:0] addr;
    logic        word;
    logic        chk_req;
    logic [22:0] exp_mem;
    logic [15:0] exp_q;
  } dem_vec_t;

  hit_vec_t hv[0:6];
  dem_vec_t dv[0:4];

  initial begin
    int base;

    hv[0] = '{24'h000100, 1'b0, 1'b0, 1'b1, 16'hBEEF};
    hv[1] = '{24'h000101, 1'b0, 1'b0, 1'b0, 16'hBEBE};
    hv[2] = '{24'h000100, 1'b0, 1'b0, 1'b0, 16'hEFEF};
    hv[3] = '{24'h000101, 1'b0, 1'b0, 1'b1, 16'hBEEF};
    hv[4] = '{24'h000100, 1'b1, 1'b0, 1'b0, 16'hBEEF};
    hv[5] = '{24'h000300, 1'b0, 1'b1, 1'b1, 16'hBEEF};
    hv[6] = '{24'h000100, 1'b0, 1'b0, 1'b0, 16'hEFEF};

    dv[0] = '{24'h000000, 1'b1, 1'b1, 23'h000000, 16'h5AC3};
    dv[1] = '{24'hFFFFFF, 1'b0, 1'b1, 23'h7FFFFF, 16'hA5A5};
    dv[2] = '{24'h000000, 1'b1, 1'b0, 23'h000000, 16'h5AC3};
    dv[3] = '{24'h123456, 1'b0, 1'b1, 23'h091A2B, 16'hE8E8};
    dv[4] = '{24'h000101, 1'b0, 1'b1, 23'h000080, 16'hBEBE};

    // Reset state
    RESET = 1'b1;
    apply(24'h0, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge MCLK);
    check("rst_mem_req", {31'd0, MEM_REQ}, 32'd0);
    check("rst_mem_addr", {9'd0, MEM_ADDR}, 32'd0);
    check("rst_rom_q", {16'd0, ROM_Q}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    RESET = 1'b0;
    tick();

    // First demand word read, ack after 3 cycles
    apply(24'h000100, 1'b0, 1'b0, 1'b1);
    tick();
    check("d1_mem_req", {31'd0, MEM_REQ}, 32'd1);
    check("d1_mem_addr", {9'd0, MEM_ADDR}, 32'h80);
    check("d1_busy", {31'd0, BUSY}, 32'd1);
    tick();
    check("d1_req_held", {31'd0, MEM_REQ}, 32'd1);
    check("d1_addr_held", {9'd0, MEM_ADDR}, 32'h80);
    tick();
    tick();
`ifdef ROM_PREFETCH_EN
    check("d1_pref_req", {31'd0, MEM_REQ}, 32'd1);
    check("d1_pref_addr", {9'd0, MEM_ADDR}, 32'h81);
`else
    check("d1_req_drop", {31'd0, MEM_REQ}, 32'd0);
`endif
    tick();
    check("d1_rom_q", {16'd0, ROM_Q}, 32'hBEEF);
    wait_idle("d1_idle");

    // Buffered hits: word/byte selection and hold with CE_N/OE_N high
    for (int i = 0; i < 7; i++) begin
      base = req_log.size();
      apply(hv[i].addr, hv[i].ce_n, hv[i].oe_n, hv[i].word);
      tick();
      check($sformatf("hit%0d_rom_q", i), {16'd0, ROM_Q}, {16'd0, hv[i].exp_q});
      check($sformatf("hit%0d_mem_req", i), {31'd0, MEM_REQ}, 32'd0);
      check($sformatf("hit%0d_busy", i), {31'd0, BUSY}, 32'd0);
      check($sformatf("hit%0d_no_fetch", i), req_log.size(), base);
    end

    // Next word: promoted from prefetch buffer, or fetched on demand
    apply(24'h000102, 1'b0, 1'b0, 1'b1);
`ifdef ROM_PREFETCH_EN
    tick();
    check("nw_no_req", {31'd0, MEM_REQ}, 32'd0);
    tick();
    check("nw_no_req2", {31'd0, MEM_REQ}, 32'd0);
    check("nw_rom_q", {16'd0, ROM_Q}, 32'h5A42);
    check("nw_req_count", req_log.size(), 2);
    if (req_log.size() == 2) begin
      check("nw_req0", {9'd0, req_log[0]}, 32'h80);
      check("nw_req1", {9'd0, req_log[1]}, 32'h81);
    end
`else
    check("nw_count_before", req_log.size(), 1);
    tick();
    wait_idle("nw_idle");
    tick();
    check("nw_rom_q", {16'd0, ROM_Q}, 32'h5A42);
    check("nw_req_count", req_log.size(), 2);
    if (req_log.size() == 2) begin
      check("nw_req1", {9'd0, req_log[1]}, 32'h81);
    end
`endif

    // Address change while waiting: first data discarded, new demand issued
    reset_pulse();
    lat  = 4;
    base = req_log.size();
    apply(24'h000100, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    check("mv_wait_req", {31'd0, MEM_REQ}, 32'd1);
    check("mv_wait_addr", {9'd0, MEM_ADDR}, 32'h80);
    apply(24'h000200, 1'b0, 1'b0, 1'b1);
    tick();
    wait_idle("mv_idle");
    tick();
    check("mv_req_count", {31'd0, req_log.size() >= base + 2}, 32'd1);
    if (req_log.size() >= base + 2) begin
      check("mv_req0", {9'd0, req_log[base]}, 32'h80);
      check("mv_req1", {9'd0, req_log[base+1]}, 32'h100);
    end
    check("mv_rom_q", {16'd0, ROM_Q}, 32'h5BC3);
    lat = 3;

    // Reset during WAIT, then a late ack
    auto_ack = 1'b0;
    apply(24'h000400, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    check("ra_wait_req", {31'd0, MEM_REQ}, 32'd1);
    RESET = 1'b1;
    #1;
    check("ra_mem_req", {31'd0, MEM_REQ}, 32'd0);
    check("ra_rom_q", {16'd0, ROM_Q}, 32'd0);
    check("ra_busy", {31'd0, BUSY}, 32'd0);
    @(negedge MCLK);
    RESET = 1'b0;
    apply(24'h000400, 1'b1, 1'b0, 1'b1);
    man_q = 16'h1234;
    man_seq++;
    tick();
    tick();
    tick();
    check("ra_late_rom_q", {16'd0, ROM_Q}, 32'd0);
    check("ra_late_req", {31'd0, MEM_REQ}, 32'd0);
    apply(24'h000100, 1'b0, 1'b0, 1'b1);
    tick();
    check("ra_valid_cleared", {31'd0, MEM_REQ}, 32'd1);
    auto_ack = 1'b1;
    wait_idle("ra_idle");

    // Demand misses across the address range, including wrap to zero
    for (int i = 0; i < 5; i++) begin
      base = req_log.size();
      apply(dv[i].addr, 1'b0, 1'b0, dv[i].word);
      tick();
      wait_idle($sformatf("dm%0d_idle", i));
      tick();
      check($sformatf("dm%0d_rom_q", i), {16'd0, ROM_Q}, {16'd0, dv[i].exp_q});
      if (dv[i].chk_req) begin
        check($sformatf("dm%0d_req_seen", i), {31'd0, req_log.size() > base}, 32'd1);
        if (req_log.size() > base) begin
          check($sformatf("dm%0d_mem_addr", i), {9'd0, req_log[base]}, {9'd0, dv[i].exp_mem});
        end
      end
    end

    // Top-of-range read: prefetch address wraps
    base = req_log.size();
    apply(24'hFFFFFE, 1'b0, 1'b0, 1'b1);
    tick();
    wait_idle("top_idle");
    tick();
    check("top_rom_q", {16'd0, ROM_Q}, 32'hA53C);
`ifdef ROM_PREFETCH_EN
    check("top_req_count", req_log.size(), base + 2);
    if (req_log.size() == base + 2) begin
      check("top_req0", {9'd0, req_log[base]}, 32'h7FFFFF);
      check("top_pref_wrap", {9'd0, req_log[base+1]}, 32'h0);
    end
`else
    check("top_req_count", req_log.size(), base + 1);
    if (req_log.size() == base + 1) begin
      check("top_req0", {9'd0, req_log[base]}, 32'h7FFFFF);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
